// File: rtl/class_histogram.sv
// class_histogram
//   Per-frame histogram of pixel classes coming out of an upstream max stage.
//   Each accepted pixel is classed as its winning channel index (0..2) or as
//   class 3 when its score is below the threshold captured at start of frame
//   (index 3 is also class 3). At end of frame the four counts, the sticky
//   saturation flag and the argmax of classes 0..2 are published with a
//   one-cycle out_valid pulse.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset, overrides everything incl. ce
//   ce         : clock enable for state, counters, threshold and out_valid
//   in_valid   : pixel qualifier
//   sof / eof  : start / end of frame strobes (eof marks the last pixel)
//   value      : winning-channel score
//   index      : winning-channel index (0 red, 1 green, 2 blue)
//   threshold  : minimum score for a pixel to be classified
//   cnt0..cnt3 : reported per-class counts (cnt3 = rejected)
//   winner     : class 0..2 with most pixels, lowest index on ties, 3 if all zero
//   overflow   : a counter saturated during the reported frame
//   out_valid  : one-cycle pulse when the reported values update
//
// SatMax is the saturation ceiling of every accumulator. It defaults to the
// full 20-bit range; it exists so a smaller ceiling can be exercised quickly.
module class_histogram #(
   parameter logic [19:0] SatMax = 20'hFFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        in_valid,
   input  logic        sof,
   input  logic        eof,
   input  logic [9:0]  value,
   input  logic [1:0]  index,
   input  logic [9:0]  threshold,
   output logic [19:0] cnt0,
   output logic [19:0] cnt1,
   output logic [19:0] cnt2,
   output logic [19:0] cnt3,
   output logic [1:0]  winner,
   output logic        overflow,
   output logic        out_valid
);

   typedef enum logic [1:0] {StIdle, StAccum, StReport} state_e;

   state_e      state;
   logic [19:0] acc [4];
   logic [19:0] acc_d [4];
   logic [9:0]  thr_frame;
   logic        frame_ovf;
   logic        ovf_d;
   logic        rpt_phase;
   logic [1:0]  win_stage;
   logic [1:0]  win_comb;

   logic        start;
   logic        accept;
   logic [9:0]  thr_eff;
   logic [1:0]  cls;

   // A sof in IDLE or ACCUM opens a fresh frame; its own pixel is classified
   // against the threshold being sampled in that same cycle.
   always_comb begin
      start   = sof && (state == StIdle || state == StAccum);
      accept  = in_valid && (state == StAccum || (state == StIdle && sof));
      thr_eff = start ? threshold : thr_frame;
      cls     = (value < thr_eff || index == 2'd3) ? 2'd3 : index;
   end

   // Next accumulator values: optional clear, then one saturating increment.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         acc_d[k] = start ? 20'd0 : acc[k];
      end
      ovf_d = start ? 1'b0 : frame_ovf;
      if (accept) begin
         if (acc_d[cls] >= SatMax) begin
            ovf_d = 1'b1;
         end else begin
            acc_d[cls] = acc_d[cls] + 20'd1;
         end
      end
   end

   // Argmax over classes 0..2; strict compare keeps the lowest index on ties
   // and leaves 3 when every count is zero.
   always_comb begin
      logic [19:0] best_cnt;
      best_cnt = 20'd0;
      win_comb = 2'd3;
      for (int k = 0; k < 3; k++) begin
         if (acc[k] > best_cnt) begin
            best_cnt = acc[k];
            win_comb = k[1:0];
         end
      end
   end

   // REPORT takes two enabled cycles: the first registers the argmax, the
   // second publishes everything, so out_valid rises two edges after eof.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         for (int k = 0; k < 4; k++) acc[k] <= 20'd0;
         thr_frame <= 10'd0;
         frame_ovf <= 1'b0;
         rpt_phase <= 1'b0;
         win_stage <= 2'd0;
         cnt0      <= 20'd0;
         cnt1      <= 20'd0;
         cnt2      <= 20'd0;
         cnt3      <= 20'd0;
         winner    <= 2'd0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (ce) begin
            unique case (state)
               StIdle: begin
                  rpt_phase <= 1'b0;
                  if (sof) begin
                     for (int k = 0; k < 4; k++) acc[k] <= acc_d[k];
                     frame_ovf <= ovf_d;
                     thr_frame <= threshold;
                     state     <= eof ? StReport : StAccum;
                  end
               end
               StAccum: begin
                  for (int k = 0; k < 4; k++) acc[k] <= acc_d[k];
                  frame_ovf <= ovf_d;
                  rpt_phase <= 1'b0;
                  if (sof) begin
                     thr_frame <= threshold;
                  end else if (eof) begin
                     state <= StReport;
                  end
               end
               StReport: begin
                  if (!rpt_phase) begin
                     win_stage <= win_comb;
                     rpt_phase <= 1'b1;
                  end else begin
                     cnt0      <= acc[0];
                     cnt1      <= acc[1];
                     cnt2      <= acc[2];
                     cnt3      <= acc[3];
                     overflow  <= frame_ovf;
                     winner    <= win_stage;
                     out_valid <= 1'b1;
                     rpt_phase <= 1'b0;
                     state     <= StIdle;
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_class_histogram.sv
// Scoreboard bench for class_histogram: the stimulus process pushes the
// hand-computed report for each frame, the monitor pops and compares on
// every out_valid pulse. A small saturation ceiling keeps the overflow
// frame short.
module tb_class_histogram;

   localparam logic [19:0] Sat = 20'd20;

   typedef struct packed {
      logic [19:0] c0;
      logic [19:0] c1;
      logic [19:0] c2;
      logic [19:0] c3;
      logic [1:0]  win;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, ce, in_valid, sof, eof;
   logic [9:0]  value, threshold;
   logic [1:0]  index;
   logic [19:0] cnt0, cnt1, cnt2, cnt3;
   logic [1:0]  winner;
   logic        overflow, out_valid;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   class_histogram #(.SatMax(Sat)) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .in_valid  (in_valid),
      .sof       (sof),
      .eof       (eof),
      .value     (value),
      .index     (index),
      .threshold (threshold),
      .cnt0      (cnt0),
      .cnt1      (cnt1),
      .cnt2      (cnt2),
      .cnt3      (cnt3),
      .winner    (winner),
      .overflow  (overflow),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   // Monitor: every pulse must match the oldest expected report.
   always @(negedge clk) begin
      if (out_valid) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out_valid: got pulse want none (cnt0=%0d cnt1=%0d)",
                     cnt0, cnt1);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("cnt0", int'(cnt0), int'(e.c0));
            chk("cnt1", int'(cnt1), int'(e.c1));
            chk("cnt2", int'(cnt2), int'(e.c2));
            chk("cnt3", int'(cnt3), int'(e.c3));
            chk("winner", int'(winner), int'(e.win));
            chk("overflow", int'(overflow), int'(e.ovf));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input logic s, input logic e, input int v, input int i);
      ce       = 1'b1;
      in_valid = 1'b1;
      sof      = s;
      eof      = e;
      value    = 10'(v);
      index    = 2'(i);
      tick();
      in_valid = 1'b0;
      sof      = 1'b0;
      eof      = 1'b0;
   endtask

   task automatic expect_rpt(input int c0, input int c1, input int c2, input int c3,
                             input int w, input int o);
      exp_t e;
      e.c0  = 20'(c0);
      e.c1  = 20'(c1);
      e.c2  = 20'(c2);
      e.c3  = 20'(c3);
      e.win = 2'(w);
      e.ovf = 1'(o);
      q.push_back(e);
   endtask

   // Bounded wait for the monitor to consume all expected reports.
   task automatic drain(input string name);
      for (int n = 0; n < 12 && q.size() != 0; n++) tick();
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL %s_report_missing: got %0d pending want 0", name, q.size());
         q.delete();
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; ce = 1'b0; in_valid = 1'b0; sof = 1'b0; eof = 1'b0;
      value = '0; index = '0; threshold = 10'd100;
      tick(); tick();
      rst = 1'b0;
      chk("rst_cnt0", int'(cnt0), 0);
      chk("rst_cnt3", int'(cnt3), 0);
      chk("rst_winner", int'(winner), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_out_valid", int'(out_valid), 0);

      // IDLE without sof: eof / in_valid are ignored, no report expected.
      pix(1'b0, 1'b1, 300, 0);
      repeat (4) tick();

      // Basic frame, threshold 100.
      threshold = 10'd100;
      expect_rpt(3, 1, 1, 1, 0, 0);
      pix(1'b1, 1'b0, 200, 0);
      pix(1'b0, 1'b0, 150, 1);
      pix(1'b0, 1'b0, 300, 0);
      pix(1'b0, 1'b0, 50, 2);
      pix(1'b0, 1'b0, 120, 2);
      pix(1'b0, 1'b1, 101, 0);
      drain("basic");

      // Tie 2/2 between classes 1 and 2; mid-frame threshold change ignored;
      // index 3 lands in class 3 even above threshold.
      threshold = 10'd10;
      expect_rpt(0, 2, 2, 1, 1, 0);
      pix(1'b1, 1'b0, 20, 1);
      threshold = 10'd1000;
      pix(1'b0, 1'b0, 30, 2);
      pix(1'b0, 1'b0, 40, 1);
      pix(1'b0, 1'b0, 60, 3);
      pix(1'b0, 1'b1, 50, 2);
      drain("tie");

      // All pixels below threshold.
      threshold = 10'd500;
      expect_rpt(0, 0, 0, 3, 3, 0);
      pix(1'b1, 1'b0, 100, 0);
      pix(1'b0, 1'b0, 100, 1);
      pix(1'b0, 1'b1, 100, 2);
      drain("all_reject");

      // sof+eof same cycle, with latency check.
      threshold = 10'd10;
      expect_rpt(0, 0, 1, 0, 2, 0);
      pix(1'b1, 1'b1, 500, 2);
      chk("lat_edge0", int'(out_valid), 0);
      tick();
      chk("lat_edge1", int'(out_valid), 0);
      tick();
      chk("lat_edge2", int'(out_valid), 1);
      drain("single");

      // Restart mid-frame: first four pixels discarded.
      expect_rpt(2, 0, 0, 0, 0, 0);
      pix(1'b1, 1'b0, 200, 1);
      pix(1'b0, 1'b0, 200, 2);
      pix(1'b0, 1'b0, 200, 1);
      pix(1'b0, 1'b0, 5, 0);
      pix(1'b1, 1'b0, 200, 0);
      pix(1'b0, 1'b1, 300, 0);
      drain("restart");

      // Clock enable low for three cycles mid-frame, strobes active.
      expect_rpt(0, 2, 0, 0, 1, 0);
      pix(1'b1, 1'b0, 50, 1);
      ce = 1'b0; in_valid = 1'b1; eof = 1'b1; value = 10'd50; index = 2'd0;
      tick(); tick(); tick();
      eof = 1'b0; in_valid = 1'b0;
      pix(1'b0, 1'b1, 50, 1);
      drain("ce_hold");

      // Saturation: Sat+2 class-1 pixels, then a clean frame.
      expect_rpt(0, int'(Sat), 0, 0, 1, 1);
      pix(1'b1, 1'b0, 50, 1);
      for (int n = 0; n < int'(Sat); n++) pix(1'b0, 1'b0, 50, 1);
      pix(1'b0, 1'b1, 50, 1);
      drain("saturate");
      expect_rpt(1, 0, 0, 0, 0, 0);
      pix(1'b1, 1'b1, 50, 0);
      drain("after_sat");

      // Reset inside ACCUM: frame dropped, outputs zeroed, no pulse.
      pix(1'b1, 1'b0, 200, 0);
      pix(1'b0, 1'b0, 200, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_cnt0", int'(cnt0), 0);
      chk("mid_rst_cnt1", int'(cnt1), 0);
      chk("mid_rst_winner", int'(winner), 0);
      chk("mid_rst_out_valid", int'(out_valid), 0);
      pix(1'b0, 1'b1, 200, 0);
      repeat (6) tick();
      chk("final_queue", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/class_histogram.md
CLASS_HISTOGRAM -- requirements
Module: class_histogram

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset with priority over all other inputs, including ce.
REQ-003 SHALL have port ce, input, 1, clock enable; when 0, state, counters, threshold and out_valid hold, except as REQ-021 states.
REQ-004 SHALL have port in_valid, input, 1, value/index qualifier.
REQ-005 SHALL have port sof, input, 1, start-of-frame strobe.
REQ-006 SHALL have port eof, input, 1, end-of-frame strobe, marking the last pixel of the frame.
REQ-007 SHALL have port value, input, 10, winning-channel score from the upstream max stage.
REQ-008 SHALL have port index, input, 2, winning-channel index from the max stage: 0=red, 1=green, 2=blue.
REQ-009 SHALL have port threshold, input, 10, minimum score for a pixel to count as classified.
REQ-010 SHALL have ports cnt0, cnt1, cnt2, cnt3, output, 20 each, per-frame counts for classes 0/1/2 and class 3 (rejected).
REQ-011 SHALL have port winner, output, 2, class with the most pixels among classes 0..2.
REQ-012 SHALL have port overflow, output, 1, set when any counter saturated during the reported frame.
REQ-013 SHALL have port out_valid, output, 1, one-cycle pulse marking new cnt*/winner/overflow values.

Function
REQ-014 SHALL implement the states IDLE, ACCUM and REPORT; all transitions require ce=1.
REQ-015 SHALL make a pixel "accepted" in a cycle when ce=1, in_valid=1 and the state is ACCUM, or the state is IDLE with sof=1.
REQ-016 SHALL, in IDLE with sof=1, clear the internal accumulators, sample threshold into a frame register, count that cycle's pixel if accepted, and enter ACCUM, or enter REPORT if eof=1 in the same cycle.
REQ-017 SHALL classify each accepted pixel as class 3 if value < frame threshold, otherwise as class index; index=3 counts as class 3.
REQ-018 SHALL increment exactly one 20-bit accumulator per accepted pixel and saturate it at 1048575; a saturating increment sets the sticky frame-overflow bit.
REQ-019 SHALL, in ACCUM with sof=1, discard the current frame: clear the accumulators and overflow, resample threshold, count the pixel, stay in ACCUM, and produce no report; sof takes precedence over eof.
REQ-020 SHALL, in ACCUM with eof=1 and sof=0, count that cycle's pixel and then enter REPORT.
REQ-021 SHALL, in REPORT, load cnt0..cnt3, overflow and winner from the accumulators, assert out_valid for exactly one cycle, and return to IDLE; out_valid clears on the next edge regardless of ce.
REQ-022 SHALL therefore rise out_valid on the second rising edge after the edge that sampled eof, with ce held at 1.
REQ-023 SHALL compute winner as the argmax of the class 0..2 accumulators, with ties resolved to the lowest index; winner=3 when all three are zero.
REQ-024 SHALL hold the reported outputs stable between reports.
REQ-025 SHALL ignore eof, in_valid and threshold changes in IDLE without sof.
REQ-026 SHALL ignore sof, eof and in_valid in REPORT, and ignore threshold changes within a frame.

Reset
REQ-027 SHALL, on rst=1, enter IDLE and zero the accumulators, the frame threshold, cnt0..cnt3 and overflow, set winner=0 and out_valid=0.
REQ-028 SHALL, if rst occurs mid-frame or in REPORT, drop the frame with no out_valid pulse.

Verification
REQ-029 SHALL cover: threshold=100; sof on pixel 1 and eof on pixel 6 with (value,index) = (200,0),(150,1),(300,0),(50,2),(120,2),(101,0) -> one out_valid pulse with cnt0=3, cnt1=1, cnt2=1, cnt3=1, winner=0, overflow=0.
REQ-030 SHALL cover: a tie of 2 pixels in class 1 and 2 pixels in class 2, with class 0 empty -> winner=1; a frame where every pixel has value<threshold -> cnt3=N and winner=3.
REQ-031 SHALL cover: sof and eof in the same cycle from IDLE with (500,2) and threshold=10 -> cnt2=1, all other counts 0, out_valid rising 2 edges later.
REQ-032 SHALL cover: sof mid-frame after 4 pixels, then 2 class-0 pixels ending in eof -> cnt0=2 and a single out_valid pulse.
REQ-033 SHALL cover: 1048577 class-1 pixels -> cnt1=1048575, overflow=1; the next frame reports overflow=0.
REQ-034 SHALL cover: ce=0 for 3 cycles with in_valid=1 mid-frame -> counts unchanged; rst asserted in ACCUM -> no out_valid pulse and all outputs zero.
